pe_cache_port: RTL and testbench

Memory-side port of one memory-access PE in the CGRA. It accepts the PE's cache requests (valid, write flag, address, write data) and buffers writes in a small posted-write FIFO. It issues requests one at a time to the shared cache/memory over a request/grant plus read-valid handshake, and returns read data to the PE's cache-data input. It drives a stall that the array controller ANDs into the global enable, so the PE freezes while a read is outstanding or the write buffer is full.

---
 rtl/pe_cache_port_pkg.sv | 21 ++
 rtl/pe_wbuf_fifo.sv | 75 +++++++
 rtl/pe_cache_port.sv | 149 ++++++++++++++
 tb/tb_pe_cache_port.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pe_cache_port_pkg.sv
// Shared definitions for the PE memory-side cache port: FSM encodings,
// the default posted-write buffer depth and a read-busy decode helper.
package pe_cache_port_pkg;

    localparam int unsigned WBUF_DEPTH_DEFAULT = 32'd4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_ISSUE = 3'd1,
        S_RD_DRAIN = 3'd2,
        S_RD_ISSUE = 3'd3,
        S_RD_WAIT  = 3'd4,
        S_RD_DONE  = 3'd5
    } state_t;

    // States in which a read is outstanding and the PE must stay frozen.
    function automatic logic rd_busy(input state_t s);
        return (s == S_RD_DRAIN) || (s == S_RD_ISSUE) || (s == S_RD_WAIT);
    endfunction

endpackage

// File: rtl/pe_wbuf_fifo.sv
// Posted-write FIFO: synchronous push/pop, head visible combinationally,
// pointers wrap modulo DEPTH (power of 2), count is log2(DEPTH)+1 bits.
module pe_wbuf_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == {CW{1'b0}});
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, push_ok_s} - {{AW{1'b0}}, pop_ok_s};
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer and count registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until pushed.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/pe_cache_port.sv
// Memory-side port of a CGRA memory PE: posts writes through a small FIFO,
// serialises blocking reads behind them and stalls the array while needed.
module pe_cache_port
    import pe_cache_port_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned CACHE_ADDR_WIDTH = 32,
    parameter int unsigned WBUF_DEPTH       = WBUF_DEPTH_DEFAULT
) (
    input  logic                        CLK_I,
    input  logic                        RST_N_I,
    input  logic                        PE_VALID_I,
    input  logic                        PE_WR_I,
    input  logic [CACHE_ADDR_WIDTH-1:0] PE_ADDR_I,
    input  logic [DATA_WIDTH-1:0]       PE_WDATA_I,
    output logic [DATA_WIDTH-1:0]       PE_RDATA_O,
    output logic                        STALL_O,
    output logic                        MEM_REQ_O,
    output logic                        MEM_WR_O,
    output logic [CACHE_ADDR_WIDTH-1:0] MEM_ADDR_O,
    output logic [DATA_WIDTH-1:0]       MEM_WDATA_O,
    input  logic                        MEM_GNT_I,
    input  logic                        MEM_RVALID_I,
    input  logic [DATA_WIDTH-1:0]       MEM_RDATA_I,
    output logic                        WBUF_EMPTY_O
);

    localparam int unsigned CW = $clog2(WBUF_DEPTH) + 1;
    localparam int unsigned EW = CACHE_ADDR_WIDTH + DATA_WIDTH;

    state_t                      state_q;
    state_t                      state_d;
    logic [CACHE_ADDR_WIDTH-1:0] rd_addr_q;
    logic [CACHE_ADDR_WIDTH-1:0] rd_addr_d;
    logic [DATA_WIDTH-1:0]       rdata_q;
    logic [DATA_WIDTH-1:0]       rdata_d;

    logic [EW-1:0]               head_s;
    logic [CACHE_ADDR_WIDTH-1:0] head_addr_s;
    logic [DATA_WIDTH-1:0]       head_data_s;
    logic                        full_s;
    logic                        empty_s;
    logic [CW-1:0]               count_s;
    logic [CW-1:0]               cnt_next_s;
    logic                        push_s;
    logic                        pop_s;
    logic                        rd_req_s;
    logic                        issuing_wr_s;
    logic                        drained_s;

    pe_wbuf_fifo #(
        .WIDTH (EW),
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk_i   (CLK_I),
        .rst_n_i (RST_N_I),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i ({PE_ADDR_I, PE_WDATA_I}),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count_s)
    );

    assign head_addr_s = head_s[EW-1 -: CACHE_ADDR_WIDTH];
    assign head_data_s = head_s[DATA_WIDTH-1:0];

    // Writes keep draining while a read waits in RD_DRAIN, so the read is
    // ordered behind every earlier write without dropping an ungranted one.
    assign issuing_wr_s = ((state_q == S_WR_ISSUE) || (state_q == S_RD_DRAIN)) & ~empty_s;
    assign push_s       = PE_VALID_I & PE_WR_I & ~full_s;
    assign pop_s        = issuing_wr_s & MEM_GNT_I;
    assign rd_req_s     = PE_VALID_I & ~PE_WR_I &
                          ((state_q == S_IDLE) || (state_q == S_WR_ISSUE));
    assign cnt_next_s   = count_s + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
    assign drained_s    = (cnt_next_s == {CW{1'b0}});

    assign STALL_O      = rd_busy(state_q) | rd_req_s | (PE_VALID_I & PE_WR_I & full_s);
    assign MEM_REQ_O    = issuing_wr_s | (state_q == S_RD_ISSUE);
    assign MEM_WR_O     = issuing_wr_s;
    assign MEM_ADDR_O   = issuing_wr_s ? head_addr_s :
                          ((state_q == S_RD_ISSUE) ? rd_addr_q : {CACHE_ADDR_WIDTH{1'b0}});
    assign MEM_WDATA_O  = issuing_wr_s ? head_data_s : {DATA_WIDTH{1'b0}};
    assign PE_RDATA_O   = rdata_q;
    assign WBUF_EMPTY_O = empty_s;

    // Next-state logic for the request sequencer.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rdata_d   = rdata_q;
        case (state_q)
            S_IDLE, S_WR_ISSUE: begin
                if (rd_req_s) begin
                    rd_addr_d = PE_ADDR_I;
                    state_d   = drained_s ? S_RD_ISSUE : S_RD_DRAIN;
                end else if (!drained_s) begin
                    state_d = S_WR_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_DRAIN: begin
                if (drained_s) begin
                    state_d = S_RD_ISSUE;
                end else begin
                    state_d = S_RD_DRAIN;
                end
            end
            S_RD_ISSUE: begin
                if (MEM_GNT_I) begin
                    state_d = S_RD_WAIT;
                end else begin
                    state_d = S_RD_ISSUE;
                end
            end
            S_RD_WAIT: begin
                if (MEM_RVALID_I) begin
                    rdata_d = MEM_RDATA_I;
                    state_d = S_RD_DONE;
                end else begin
                    state_d = S_RD_WAIT;
                end
            end
            // The PE consumes the data here; its held read is not re-issued.
            S_RD_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM, captured read address and returned read data.
    always_ff @(posedge CLK_I) begin
        if (!RST_N_I) begin
            state_q   <= S_IDLE;
            rd_addr_q <= {CACHE_ADDR_WIDTH{1'b0}};
            rdata_q   <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_pe_cache_port.sv
// Directed bench for pe_cache_port: a per-cycle vector table plus
// hand-written sequences for FIFO-full, slow memory and reset-in-read.
module tb_pe_cache_port;

    logic        clk;
    logic        rst_n;
    logic        pe_valid;
    logic        pe_wr;
    logic [31:0] pe_addr;
    logic [31:0] pe_wdata;
    logic [31:0] pe_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wbuf_empty;

    int n_tests = 0;
    int n_fail  = 0;

    pe_cache_port #(
        .DATA_WIDTH       (32),
        .CACHE_ADDR_WIDTH (32),
        .WBUF_DEPTH       (4)
    ) dut (
        .CLK_I        (clk),
        .RST_N_I      (rst_n),
        .PE_VALID_I   (pe_valid),
        .PE_WR_I      (pe_wr),
        .PE_ADDR_I    (pe_addr),
        .PE_WDATA_I   (pe_wdata),
        .PE_RDATA_O   (pe_rdata),
        .STALL_O      (stall),
        .MEM_REQ_O    (mem_req),
        .MEM_WR_O     (mem_wr),
        .MEM_ADDR_O   (mem_addr),
        .MEM_WDATA_O  (mem_wdata),
        .MEM_GNT_I    (mem_gnt),
        .MEM_RVALID_I (mem_rvalid),
        .MEM_RDATA_I  (mem_rdata),
        .WBUF_EMPTY_O (wbuf_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        valid;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        e_stall;
        logic        e_req;
        logic        e_wr;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic [31:0] e_prdata;
        logic        e_empty;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mkv(input string nm, input logic r, input logic v, input logic w,
                                 input logic [31:0] a, input logic [31:0] d, input logic g,
                                 input logic rv, input logic [31:0] rd, input logic es,
                                 input logic eq, input logic ew, input logic [31:0] ea,
                                 input logic [31:0] ed, input logic [31:0] ep, input logic ee);
        vec_t x;
        x.name = nm; x.rst_n = r; x.valid = v; x.wr = w; x.addr = a; x.wdata = d;
        x.gnt = g; x.rvalid = rv; x.rdata = rd; x.e_stall = es; x.e_req = eq;
        x.e_wr = ew; x.e_maddr = ea; x.e_mwdata = ed; x.e_prdata = ep; x.e_empty = ee;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic g, input logic rv,
                         input logic [31:0] rd);
        rst_n = r; pe_valid = v; pe_wr = w; pe_addr = a; pe_wdata = d;
        mem_gnt = g; mem_rvalid = rv; mem_rdata = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int stall_cnt;
    int req_cnt;
    int req_bad;

    initial begin
        vecs[0]  = mkv("reset_wr",  1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,
                       1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        32'h0,    1'b1);
        vecs[1]  = mkv("wr_accept", 1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,
                       1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        32'h0,    1'b1);
        vecs[2]  = mkv("wr_issue",  1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h0,
                       1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0,    1'b0);
        vecs[3]  = mkv("wr_idle",   1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,
                       1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        32'h0,    1'b1);
        vecs[4]  = mkv("bw1",       1'b1, 1'b1, 1'b1, 32'h20, 32'h11111111, 1'b0, 1'b0, 32'h0,
                       1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        32'h0,    1'b1);
        vecs[5]  = mkv("bw2",       1'b1, 1'b1, 1'b1, 32'h24, 32'h22222222, 1'b0, 1'b0, 32'h0,
                       1'b0, 1'b1, 1'b1, 32'h20, 32'h11111111, 32'h0,    1'b0);
        vecs[6]  = mkv("rd_seen",   1'b1, 1'b1, 1'b0, 32'h10, 32'h0,        1'b1, 1'b0, 32'h0,
                       1'b1, 1'b1, 1'b1, 32'h20, 32'h11111111, 32'h0,    1'b0);
        vecs[7]  = mkv("rd_drain",  1'b1, 1'b1, 1'b0, 32'h10, 32'h0,        1'b1, 1'b0, 32'h0,
                       1'b1, 1'b1, 1'b1, 32'h24, 32'h22222222, 32'h0,    1'b0);
        vecs[8]  = mkv("rd_issue",  1'b1, 1'b1, 1'b0, 32'h10, 32'h0,        1'b1, 1'b0, 32'h0,
                       1'b1, 1'b1, 1'b0, 32'h10, 32'h0,        32'h0,    1'b1);
        vecs[9]  = mkv("rd_wait",   1'b1, 1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b1, 32'h1234,
                       1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        32'h0,    1'b1);
        vecs[10] = mkv("rd_done",   1'b1, 1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h0,
                       1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        32'h1234, 1'b1);
        vecs[11] = mkv("rd_after",  1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,
                       1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        32'h1234, 1'b1);

        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (2) next_cycle();

        // Table: one row per clock cycle, outputs sampled at the falling edge.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rst_n, vecs[i].valid, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                  vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata);
            @(negedge clk);
            chk({vecs[i].name, ".stall"},  {31'd0, stall},      {31'd0, vecs[i].e_stall});
            chk({vecs[i].name, ".req"},    {31'd0, mem_req},    {31'd0, vecs[i].e_req});
            chk({vecs[i].name, ".mem_wr"}, {31'd0, mem_wr},     {31'd0, vecs[i].e_wr});
            chk({vecs[i].name, ".maddr"},  mem_addr,            vecs[i].e_maddr);
            chk({vecs[i].name, ".mwdata"}, mem_wdata,           vecs[i].e_mwdata);
            chk({vecs[i].name, ".prdata"}, pe_rdata,            vecs[i].e_prdata);
            chk({vecs[i].name, ".empty"},  {31'd0, wbuf_empty}, {31'd0, vecs[i].e_empty});
            next_cycle();
        end

        // FIFO full: five writes with no grant, then one pop unblocks the fifth.
        for (int i = 0; i < 6; i++) begin
            int k;
            k = (i < 5) ? i : 4;
            drive(1'b1, 1'b1, 1'b1, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k), 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            chk($sformatf("full.stall%0d", i), {31'd0, stall}, {31'd0, (i >= 4)});
            next_cycle();
        end
        drive(1'b1, 1'b1, 1'b1, 32'h110, 32'hA4, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("full.pop_cycle_stall", {31'd0, stall}, 32'd1);
        chk("full.head0", mem_addr, 32'h100);
        next_cycle();
        drive(1'b1, 1'b1, 1'b1, 32'h110, 32'hA4, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("full.unblock_stall", {31'd0, stall}, 32'd0);
        next_cycle();
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
            @(negedge clk);
            chk($sformatf("drain.req%0d", j), {31'd0, mem_req}, 32'd1);
            chk($sformatf("drain.addr%0d", j), mem_addr, 32'h104 + 32'(4 * j));
            chk($sformatf("drain.data%0d", j), mem_wdata, 32'hA1 + 32'(j));
            next_cycle();
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("drain.empty", {31'd0, wbuf_empty}, 32'd1);
        chk("drain.req_off", {31'd0, mem_req}, 32'd0);
        next_cycle();

        // Slow memory: grant on the 4th issue cycle, rvalid 2 cycles later.
        stall_cnt = 0; req_cnt = 0; req_bad = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, (i <= 7), 1'b0, 32'h40, 32'h0, (i == 4), (i == 6),
                  (i == 6) ? 32'hCAFEF00D : 32'h0);
            @(negedge clk);
            if (stall) stall_cnt++;
            if (mem_req) begin
                req_cnt++;
                if (mem_addr !== 32'h40 || mem_wr !== 1'b0) req_bad++;
            end
            if (i == 7) begin
                chk("slow.done_stall", {31'd0, stall}, 32'd0);
                chk("slow.done_data", pe_rdata, 32'hCAFEF00D);
            end
            next_cycle();
        end
        chk("slow.stall_cycles", 32'(stall_cnt), 32'd7);
        chk("slow.req_cycles", 32'(req_cnt), 32'd4);
        chk("slow.req_stable", 32'(req_bad), 32'd0);

        // Reset while waiting for read data, then a stray rvalid.
        drive(1'b1, 1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 1'b0, 32'h0);
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 1'b0, 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("rstwait.in_wait_stall", {31'd0, stall}, 32'd1);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h00000BAD);
        @(negedge clk);
        chk("rstwait.stall", {31'd0, stall}, 32'd0);
        chk("rstwait.req", {31'd0, mem_req}, 32'd0);
        chk("rstwait.prdata", pe_rdata, 32'h0);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("rstwait.stray_ignored", pe_rdata, 32'h0);
        chk("rstwait.stall2", {31'd0, stall}, 32'd0);
        chk("rstwait.empty", {31'd0, wbuf_empty}, 32'd1);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
